// File: rtl/pe_result_drain.sv
// ---------------------------------------------------------------------------
// pe_result_drain
//
// Purpose:
//   Captures the accumulator result of every PE in a DIMENSION x DIMENSION
//   systolic array as that PE pulses its finish flag, then streams the
//   captured results out in row-major order over a valid/ready interface.
//   Each result is requantized to R_BITS: arithmetic shift right by
//   (I_BITS-1), then saturation to the signed R_BITS range.
//   Capture of the next matrix overlaps the drain per element: once an
//   element has been accepted downstream (or in the very cycle it is
//   accepted) its slot can take a new result, so the array never stalls.
//
// Ports:
//   i_clock    clock, rising edge
//   i_reset    asynchronous active-high reset
//   i_c        flattened accumulators, PE idx=r*DIMENSION+c at
//              [idx*O_BITS +: O_BITS]
//   i_finish   per-PE finish pulse (i_c slice is final while high)
//   i_ready    downstream accepts o_data this cycle
//   o_data     requantized result
//   o_valid    o_data valid (high throughout DRAIN)
//   o_row      row of o_data
//   o_col      column of o_data
//   o_last     o_valid on element N-1
//   o_busy     high while draining
//   o_overrun  sticky: a finish arrived for a slot still holding an
//              undrained result (the new value was discarded)
// ---------------------------------------------------------------------------
module pe_result_drain #(
  parameter int DIMENSION = 4,
  parameter int I_BITS    = 8,
  parameter int O_BITS    = (I_BITS * 2) + $clog2(DIMENSION),
  parameter int R_BITS    = 8
) (
  input  logic                                    i_clock,
  input  logic                                    i_reset,
  input  logic [DIMENSION*DIMENSION*O_BITS-1:0]   i_c,
  input  logic [DIMENSION*DIMENSION-1:0]          i_finish,
  input  logic                                    i_ready,
  output logic [R_BITS-1:0]                       o_data,
  output logic                                    o_valid,
  output logic [$clog2(DIMENSION)-1:0]            o_row,
  output logic [$clog2(DIMENSION)-1:0]            o_col,
  output logic                                    o_last,
  output logic                                    o_busy,
  output logic                                    o_overrun
);

  localparam int N     = DIMENSION * DIMENSION;
  localparam int PTR_W = $clog2(N);
  localparam int RC_W  = $clog2(DIMENSION);
  localparam int SHIFT = I_BITS - 1;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_DRAIN   = 1'b1
  } state_t;

  state_t            r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic [O_BITS-1:0] r_bank [N];
  logic [N-1:0]      r_flag;
  logic              r_overrun;

  logic              w_drain;
  logic              w_accept;
  logic [N-1:0]      w_accept_vec;
  logic [N-1:0]      w_capture;
  logic [N-1:0]      w_flag_next;
  logic [N-1:0]      w_overrun_vec;

  assign w_drain  = (r_state == S_DRAIN);
  assign w_accept = w_drain & i_ready;

  // Per-element capture decision. A slot accepts a new value when it is
  // empty, or when its current value leaves downstream in this same cycle.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_elem
      assign w_accept_vec[gi]  = w_accept && (r_ptr == PTR_W'(gi));
      assign w_capture[gi]     = i_finish[gi] & (~r_flag[gi] | w_accept_vec[gi]);
      assign w_flag_next[gi]   = w_capture[gi] | (r_flag[gi] & ~w_accept_vec[gi]);
      assign w_overrun_vec[gi] = i_finish[gi] & r_flag[gi] & ~w_accept_vec[gi];
    end
  endgenerate

  // Capture bank and occupancy flags
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < N; i++) begin
        r_bank[i] <= '0;
      end
      r_flag <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_capture[i]) begin
          r_bank[i] <= i_c[i*O_BITS +: O_BITS];
        end
      end
      r_flag <= w_flag_next;
    end
  end

  // Collect/drain sequencing, read pointer and sticky overrun
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_COLLECT;
      r_ptr     <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (|w_overrun_vec) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_COLLECT: begin
          // Uses the registered flags, so the drain starts one edge after
          // the last capture and never on a partially written bank.
          if (&r_flag) begin
            r_state <= S_DRAIN;
            r_ptr   <= '0;
          end
        end
        S_DRAIN: begin
          if (i_ready) begin
            if (r_ptr == PTR_W'(N - 1)) begin
              r_ptr   <= '0;
              r_state <= S_COLLECT;
            end else begin
              r_ptr <= r_ptr + PTR_W'(1);
            end
          end
        end
        default: begin
          r_state <= S_COLLECT;
        end
      endcase
    end
  end

  // Requantization of the element under the read pointer
  logic signed [O_BITS-1:0] w_sel;
  logic signed [O_BITS-1:0] w_shifted;
  logic [O_BITS-R_BITS:0]   w_upper;
  logic                     w_in_range;
  logic [R_BITS-1:0]        w_quant;

  assign w_sel     = r_bank[r_ptr];
  assign w_shifted = w_sel >>> SHIFT;
  // The value fits in R_BITS when every bit from the R_BITS sign position
  // upward is a copy of the sign.
  assign w_upper    = w_shifted[O_BITS-1:R_BITS-1];
  assign w_in_range = (&w_upper) | ~(|w_upper);
  assign w_quant    = w_in_range        ? w_shifted[R_BITS-1:0] :
                      w_shifted[O_BITS-1] ? {1'b1, {(R_BITS-1){1'b0}}} :
                                            {1'b0, {(R_BITS-1){1'b1}}};

  assign o_valid   = w_drain;
  assign o_busy    = w_drain;
  assign o_data    = w_drain ? w_quant : '0;
  assign o_row     = RC_W'(r_ptr / PTR_W'(DIMENSION));
  assign o_col     = RC_W'(r_ptr % PTR_W'(DIMENSION));
  assign o_last    = w_drain && (r_ptr == PTR_W'(N - 1));
  assign o_overrun = r_overrun;

endmodule
